// File: rtl/scope_capture_ctrl_if.sv
// Sample-in / control / s2-memory-out / status bundle for scope_capture_ctrl.
// Signals are plain wires; no handshake, the memory port always accepts.
interface scope_capture_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int SAMP_W = 12
);
  logic              samp_valid;
  logic [SAMP_W-1:0] samp_data;
  logic              arm;
  logic              abort;
  logic              force_trig;
  logic [SAMP_W-1:0] trig_level;
  logic              trig_falling;
  logic [ADDR_W-1:0] pre_count;
  logic [7:0]        decim;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [15:0]       mem_writedata;
  logic [1:0]        mem_byteenable;

  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;

  modport slave (
    input  samp_valid, samp_data, arm, abort, force_trig, trig_level, trig_falling,
           pre_count, decim,
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
           mem_byteenable, busy, done, trig_addr
  );

  modport master (
    output samp_valid, samp_data, arm, abort, force_trig, trig_level, trig_falling,
           pre_count, decim,
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
           mem_byteenable, busy, done, trig_addr
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Scope trigger/capture engine: decimates samples, detects a level crossing, writes a circular pre/post record.
// Latency: one cycle from kept samp_valid to mem_write; no backpressure, the s2 port accepts every write.
module scope_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int SAMP_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  scope_capture_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, pre_q, trig_addr_q, mem_addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [7:0]        decim_cnt_q, decim_q;
  logic [SAMP_W-1:0] prev_q, lvl_q;
  logic              fall_q, first_q, mem_wr_q, busy_q, done_q;
  logic [15:0]       mem_wd_q;

  logic              kept, active, level_hit, trig_hit;
  logic [7:0]        decim_cnt_d;
  logic [ADDR_W:0]   cnt_d, post_len;
  logic [15:0]       wd_d;

  assign kept        = bus.samp_valid && (decim_cnt_q == decim_q);
  assign active      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign decim_cnt_d = !bus.samp_valid ? decim_cnt_q : (kept ? 8'd0 : decim_cnt_q + 8'd1);
  assign cnt_d       = cnt_q + ONE_V;
  assign post_len    = DEPTH_V - {1'b0, pre_q};

  assign level_hit = fall_q ? ((prev_q >= lvl_q) && (bus.samp_data < lvl_q))
                            : ((prev_q < lvl_q) && (bus.samp_data >= lvl_q));
  // prev_q is meaningless until the first kept sample after arm has loaded it.
  assign trig_hit  = (state_q == S_WAIT) && (bus.force_trig || (!first_q && level_hit));

  always_comb begin
    wd_d = '0;
    wd_d[SAMP_W-1:0] = bus.samp_data;
    wd_d[12] = trig_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      decim_cnt_q <= '0;
      decim_q     <= '0;
      prev_q      <= '0;
      lvl_q       <= '0;
      fall_q      <= 1'b0;
      first_q     <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_wd_q    <= '0;
    end else begin
      mem_wr_q    <= 1'b0;
      decim_cnt_q <= decim_cnt_d;
      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (bus.arm && !active) begin
        pre_q       <= bus.pre_count;
        lvl_q       <= bus.trig_level;
        fall_q      <= bus.trig_falling;
        decim_q     <= bus.decim;
        decim_cnt_q <= '0;
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        first_q     <= 1'b1;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        state_q     <= (bus.pre_count == '0) ? S_WAIT : S_PRE;
      end else if (active && kept) begin
        mem_wr_q   <= 1'b1;
        mem_addr_q <= wr_ptr_q;
        mem_wd_q   <= wd_d;
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        case (state_q)
          S_PRE: begin
            prev_q  <= bus.samp_data;
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            if (cnt_d == {1'b0, pre_q}) state_q <= S_WAIT;
          end
          S_WAIT: begin
            prev_q  <= bus.samp_data;
            first_q <= 1'b0;
            if (trig_hit) begin
              trig_addr_q <= wr_ptr_q;
              cnt_q       <= ONE_V;
              // With pre_count = depth-1 the trigger sample alone completes the record.
              if (post_len == ONE_V) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end
          S_POST: begin
            cnt_q <= cnt_d;
            if (cnt_d == post_len) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_chipselect = mem_wr_q;
  assign bus.mem_write      = mem_wr_q;
  assign bus.mem_writedata  = mem_wd_q;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_byteenable = 2'b11;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.trig_addr      = trig_addr_q;
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: vector table, directed capture sequences, random run against a record-level model.
module tb_scope_capture_ctrl;
  localparam int AW = 9;
  localparam int SW = 12;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;

  scope_capture_ctrl_if #(.ADDR_W(AW), .SAMP_W(SW)) bus ();
  scope_capture_ctrl #(.ADDR_W(AW), .SAMP_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // configuration presented on the bus every cycle
  int cfg_pre, cfg_lvl, cfg_fall, cfg_decim;

  // record-level model
  bit m_cap, m_done;
  int m_pre, m_lvl, m_fall, m_decim;
  int m_vcount, m_nkept, m_trig_idx, m_trig_addr, m_prev;
  bit e_wr;
  int e_addr, e_data;

  // observations of DUT writes
  int obs_writes, obs_tflag, obs_taddr, obs_tdata, obs_post, obs_first_addr, obs_first_data;
  bit obs_wrap;

  typedef struct {
    bit arm; bit abort; bit valid; int data;
    bit e_wr; int e_addr; int e_data; bit e_busy; int e_taddr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_trig_addr = 0; m_vcount = 0; m_decim = 0;
    m_nkept = 0; m_trig_idx = -1; m_prev = 0;
  endtask

  task automatic obs_clear();
    obs_writes = 0; obs_tflag = 0; obs_taddr = -1; obs_tdata = -1; obs_post = 0;
    obs_first_addr = -1; obs_first_data = -1; obs_wrap = 0;
  endtask

  task automatic model_step(input bit arm, input bit abort, input bit valid, input int data, input bit frc);
    bit kept, waiting, fire;
    int k;
    e_wr = 0;
    if (abort) begin
      m_cap = 0; m_done = 0;
    end else if (arm && !m_cap) begin
      m_cap = 1; m_done = 0;
      m_pre = cfg_pre; m_lvl = cfg_lvl; m_fall = cfg_fall; m_decim = cfg_decim;
      m_vcount = 0; m_nkept = 0; m_trig_idx = -1;
    end else if (valid) begin
      kept = (m_vcount % (m_decim + 1)) == m_decim;
      m_vcount++;
      if (m_cap && kept) begin
        k = m_nkept;
        e_wr = 1; e_addr = k % DEPTH; e_data = data;
        waiting = (m_trig_idx < 0);
        if (k >= m_pre && waiting) begin
          fire = frc || (k > 0 && (m_fall != 0 ? (m_prev >= m_lvl && data < m_lvl)
                                               : (m_prev < m_lvl && data >= m_lvl)));
          if (fire) begin
            m_trig_idx = k; m_trig_addr = e_addr; e_data = data + 'h1000;
          end
        end
        if (waiting) m_prev = data;
        m_nkept++;
        if (m_trig_idx >= 0 && (m_nkept - m_trig_idx) == DEPTH - m_pre) begin
          m_cap = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit arm, input bit abort, input bit valid, input int data, input bit frc);
    bus.arm = arm; bus.abort = abort; bus.samp_valid = valid; bus.samp_data = data[SW-1:0];
    bus.force_trig = frc;
    bus.pre_count = cfg_pre[AW-1:0]; bus.trig_level = cfg_lvl[SW-1:0];
    bus.trig_falling = cfg_fall[0]; bus.decim = cfg_decim[7:0];
  endtask

  task automatic observe();
    if (bus.mem_write) begin
      if (obs_writes == 0) begin
        obs_first_addr = int'(bus.mem_address); obs_first_data = int'(bus.mem_writedata);
      end
      obs_writes++;
      if (bus.mem_writedata[12]) begin
        obs_tflag++; obs_taddr = int'(bus.mem_address); obs_tdata = int'(bus.mem_writedata);
      end
      if (obs_tflag > 0) obs_post++;
      if (obs_tflag > 0 && bus.mem_address == '0) obs_wrap = 1;
    end
  endtask

  task automatic cyc(input bit arm, input bit abort, input bit valid, input int data, input bit frc);
    drive(arm, abort, valid, data, frc);
    model_step(arm, abort, valid, data, frc);
    @(posedge clk); #1;
    check("mem_write", int'(bus.mem_write), int'(e_wr));
    check("mem_chipselect", int'(bus.mem_chipselect), int'(e_wr));
    if (e_wr) begin
      check("mem_address", int'(bus.mem_address), e_addr);
      check("mem_writedata", int'(bus.mem_writedata), e_data);
    end
    check("busy", int'(bus.busy), int'(m_cap));
    check("done", int'(bus.done), int'(m_done));
    check("trig_addr", int'(bus.trig_addr), m_trig_addr);
    observe();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_address"}, int'(bus.mem_address), 0);
    check({tag, "_mem_chipselect"}, int'(bus.mem_chipselect), 0);
    check({tag, "_mem_write"}, int'(bus.mem_write), 0);
    check({tag, "_mem_writedata"}, int'(bus.mem_writedata), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_trig_addr"}, int'(bus.trig_addr), 0);
    check({tag, "_mem_clken"}, int'(bus.mem_clken), 1);
    check({tag, "_mem_byteenable"}, int'(bus.mem_byteenable), 3);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int i, p, first_pulse, s;
    bit arm, abort, valid, frc;

    cfg_pre = 0; cfg_lvl = 1000; cfg_fall = 1; cfg_decim = 0;
    do_reset();
    check_reset_vals("reset");

    // falling trigger, abort mid-POST, re-arm, arm-while-busy ignored
    vt[0] = '{1, 0, 0,    0, 0, 0,      0, 1, 0};
    vt[1] = '{0, 0, 1, 1500, 1, 0, 'h05DC, 1, 0};
    vt[2] = '{0, 0, 1, 1200, 1, 1, 'h04B0, 1, 0};
    vt[3] = '{0, 0, 1,  900, 1, 2, 'h1384, 1, 2};
    vt[4] = '{0, 0, 1,  800, 1, 3, 'h0320, 1, 2};
    vt[5] = '{0, 1, 1,  700, 0, 0,      0, 0, 2};
    vt[6] = '{1, 0, 1,  600, 0, 0,      0, 1, 2};
    vt[7] = '{0, 0, 1,  650, 1, 0, 'h028A, 1, 2};
    vt[8] = '{1, 0, 1,  400, 1, 1, 'h0190, 1, 2};
    vt[9] = '{0, 1, 0,    0, 0, 0,      0, 0, 2};
    for (int v = 0; v < 10; v++) begin
      drive(vt[v].arm, vt[v].abort, vt[v].valid, vt[v].data, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_mem_write", v), int'(bus.mem_write), int'(vt[v].e_wr));
      if (vt[v].e_wr) begin
        check($sformatf("vec%0d_mem_address", v), int'(bus.mem_address), vt[v].e_addr);
        check($sformatf("vec%0d_mem_writedata", v), int'(bus.mem_writedata), vt[v].e_data);
      end
      check($sformatf("vec%0d_busy", v), int'(bus.busy), int'(vt[v].e_busy));
      check($sformatf("vec%0d_trig_addr", v), int'(bus.trig_addr), vt[v].e_taddr);
    end

    // rising ramp capture
    do_reset();
    cfg_pre = 100; cfg_lvl = 2048; cfg_fall = 0; cfg_decim = 0;
    obs_clear();
    cyc(1, 0, 0, 0, 0);
    i = 0;
    while (!bus.done && i < 2000) begin
      cyc(0, 0, 1, (8 * i) & 4095, 0);
      i++;
    end
    check("ramp_done", int'(bus.done), 1);
    check("ramp_first_addr", obs_first_addr, 0);
    check("ramp_first_data", obs_first_data, 0);
    check("ramp_trig_addr", int'(bus.trig_addr), 256);
    check("ramp_trig_data", obs_tdata, 'h1800);
    check("ramp_post_writes", obs_post, 412);
    check("ramp_total_writes", obs_writes, 668);
    cyc(0, 0, 1, 5, 0);

    // falling from DONE, pre_count 0, full-depth POST with wrap
    cfg_pre = 0; cfg_lvl = 1000; cfg_fall = 1;
    obs_clear();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1500, 0);
    cyc(0, 0, 1, 1200, 0);
    cyc(0, 0, 1, 900, 0);
    i = 0;
    while (!bus.done && i < 1000) begin
      cyc(0, 0, 1, $urandom_range(0, 4095), 0);
      i++;
    end
    check("fall_done", int'(bus.done), 1);
    check("fall_trig_addr", int'(bus.trig_addr), 2);
    check("fall_trig_data", obs_tdata, 'h1384);
    check("fall_post_writes", obs_post, 512);
    check("fall_wrap_to_0", int'(obs_wrap), 1);

    // decimation by 4 through PRE into WAIT_TRIG
    cfg_pre = 8; cfg_lvl = 4000; cfg_fall = 0; cfg_decim = 3;
    obs_clear();
    first_pulse = 0;
    cyc(1, 0, 0, 0, 0);
    for (p = 1; p <= 40; p++) begin
      cyc(0, 0, 1, 100, 0);
      if (bus.mem_write && first_pulse == 0) first_pulse = p;
      cyc(0, 0, 0, 0, 0);
    end
    check("decim_writes", obs_writes, 10);
    check("decim_first_pulse", first_pulse, 4);
    check("decim_no_trig", obs_tflag, 0);
    for (p = 41; p <= 44; p++) cyc(0, 0, 1, 100, 1);
    check("decim_force_trig_count", obs_tflag, 1);
    check("decim_force_trig_addr", obs_taddr, 10);
    cyc(0, 1, 0, 0, 0);

    // forced trigger on a flat input
    cfg_pre = 4; cfg_lvl = 0; cfg_fall = 0; cfg_decim = 0;
    obs_clear();
    cyc(1, 0, 0, 0, 0);
    i = 0;
    while (!bus.done && i < 1000) begin
      cyc(0, 0, 1, 500, 1);
      i++;
    end
    check("force_done", int'(bus.done), 1);
    check("force_tflag_count", obs_tflag, 1);
    check("force_trig_addr", obs_taddr, 4);
    check("force_trig_data", obs_tdata, 'h11F4);

    // reset in the middle of POST
    cfg_pre = 2;
    cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 10; n++) cyc(0, 0, 1, 300, 1);
    check("midpost_busy", int'(bus.busy), 1);
    do_reset();
    check_reset_vals("midpost_reset");
    obs_clear();
    for (int n = 0; n < 20; n++) cyc(0, 0, 1, 300, 1);
    check("midpost_no_writes", obs_writes, 0);

    // random run
    s = 2048;
    for (int c = 0; c < 8000; c++) begin
      cfg_pre = $urandom_range(0, DEPTH - 1);
      cfg_lvl = $urandom_range(1500, 2500);
      cfg_fall = $urandom_range(0, 1);
      cfg_decim = $urandom_range(0, 2);
      arm = m_cap ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 999) == 0);
      valid = ($urandom_range(0, 3) != 0);
      frc = ($urandom_range(0, 299) == 0);
      s = s + int'($urandom_range(0, 160)) - 80;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      cyc(arm, abort, valid, s, frc);
    end
    check("end_mem_clken", int'(bus.mem_clken), 1);
    check("end_mem_byteenable", int'(bus.mem_byteenable), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
